// File: rtl/vc_skid_reg.sv
// Two-entry skid register: full-throughput valid/ready stage with registered recv_rdy.
// Optional flush port enabled by defining VC_SKID_REG_SQUASH_EN.
module vc_skid_reg #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
`ifdef VC_SKID_REG_SQUASH_EN
    input  logic               squash,
`endif
    input  logic               recv_val,
    output logic               recv_rdy,
    input  logic [p_nbits-1:0] recv_msg,
    output logic               send_val,
    input  logic               send_rdy,
    output logic [p_nbits-1:0] send_msg,
    output logic [1:0]         count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;
    logic               recv_go;
    logic               send_go;

    // Handshake flags come from registered state only; send_rdy never
    // reaches recv_rdy, so the upstream path stays a clean register output.
`ifdef VC_SKID_REG_SQUASH_EN
    assign recv_rdy = ~reset & ~squash & (state != FULL);
    assign send_val = ~squash & (state != EMPTY);
`else
    assign recv_rdy = ~reset & (state != FULL);
    assign send_val = (state != EMPTY);
`endif

    assign recv_go  = recv_val & recv_rdy;
    assign send_go  = send_val & send_rdy;
    assign send_msg = main_q;
    assign count    = state;

    // Occupancy FSM plus main/skid data movement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else
`ifdef VC_SKID_REG_SQUASH_EN
        if (squash) begin
            state <= EMPTY;
        end else
`endif
        begin
            case (state)
                EMPTY: begin
                    if (recv_go) begin
                        main_q <= recv_msg;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (recv_go && send_go) begin
                        main_q <= recv_msg;
                    end else if (recv_go) begin
                        skid_q <= recv_msg;
                        state  <= FULL;
                    end else if (send_go) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (send_go) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_skid_reg.sv
// Bench for vc_skid_reg: directed vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_vc_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] recv_msg;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] send_msg;
    logic [1:0]  count;
`ifdef VC_SKID_REG_SQUASH_EN
    logic        squash;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    vc_skid_reg #(.p_nbits(32)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef VC_SKID_REG_SQUASH_EN
        .squash   (squash),
`endif
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        sr;
        logic [31:0] msg;
        logic        esv;
        logic        chkm;
        logic [31:0] esm;
        logic        err;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else begin
            fails++;
            if (fails <= 25)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        int          pushed;
        int          sent;
        int          cyc;
        logic        esv;
        logic        err;
        logic [31:0] esm;
        logic        do_send;
        logic        do_recv;

        reset    = 1'b1;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        recv_msg = '0;
`ifdef VC_SKID_REG_SQUASH_EN
        squash   = 1'b0;
`endif

        vec[0]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h11, 1'b1, 2'd1};
        vec[1]  = '{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 32'h11, 1'b0, 2'd2};
        vec[2]  = '{1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 32'h11, 1'b0, 2'd2};
        vec[3]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h22, 1'b1, 2'd1};
        vec[4]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0};
        vec[5]  = '{1'b1, 1'b1, 32'hA5, 1'b1, 1'b1, 32'hA5, 1'b1, 2'd1};
        vec[6]  = '{1'b1, 1'b1, 32'hB6, 1'b1, 1'b1, 32'hB6, 1'b1, 2'd1};
        vec[7]  = '{1'b0, 1'b0, 32'h66, 1'b1, 1'b1, 32'hB6, 1'b1, 2'd1};
        vec[8]  = '{1'b1, 1'b0, 32'hC7, 1'b1, 1'b1, 32'hB6, 1'b0, 2'd2};
        vec[9]  = '{1'b1, 1'b1, 32'hD8, 1'b1, 1'b1, 32'hC7, 1'b1, 2'd1};
        vec[10] = '{1'b1, 1'b0, 32'hE9, 1'b1, 1'b1, 32'hC7, 1'b0, 2'd2};
        vec[11] = '{1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 32'hE9, 1'b1, 2'd1};
        vec[12] = '{1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_recv_rdy", 64'(recv_rdy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_send_msg", 64'(send_msg), 64'd0);
        reset = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(recv_rdy), 64'd1);

        // single message latency
        recv_val = 1'b1;
        recv_msg = 32'hA5;
        send_rdy = 1'b1;
        tick();
        chk("lat_send_val", 64'(send_val), 64'd1);
        chk("lat_send_msg", 64'(send_msg), 64'hA5);
        chk("lat_count", 64'(count), 64'd1);
        recv_val = 1'b0;
        tick();
        chk("lat_drain", 64'(count), 64'd0);

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            recv_val = vec[i].rv;
            send_rdy = vec[i].sr;
            recv_msg = vec[i].msg;
            tick();
            chk($sformatf("vec%0d_send_val", i), 64'(send_val),
                64'(vec[i].esv));
            chk($sformatf("vec%0d_recv_rdy", i), 64'(recv_rdy),
                64'(vec[i].err));
            chk($sformatf("vec%0d_count", i), 64'(count),
                64'(vec[i].ecnt));
            if (vec[i].chkm)
                chk($sformatf("vec%0d_send_msg", i), 64'(send_msg),
                    64'(vec[i].esm));
        end

        // back-to-back streaming
        for (int k = 1; k <= 8; k++) begin
            recv_val = 1'b1;
            send_rdy = 1'b1;
            recv_msg = 32'(k);
            tick();
            chk($sformatf("stream%0d", k),
                {31'd0, send_val, send_msg, recv_rdy, count},
                {31'd0, 1'b1, 32'(k), 1'b1, 2'd1});
        end
        recv_val = 1'b0;
        tick();
        chk("stream_drain", 64'(count), 64'd0);

        // reset pulse between edges while full
        send_rdy = 1'b0;
        recv_val = 1'b1;
        recv_msg = 32'h11;
        tick();
        recv_msg = 32'h22;
        tick();
        recv_val = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out", {61'd0, send_val, recv_rdy, count[0]},
            64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_release_rdy", 64'(recv_rdy), 64'd1);
        tick();
        chk("midrst_hold_empty", 64'(send_val), 64'd0);

`ifdef VC_SKID_REG_SQUASH_EN
        // squash while full
        send_rdy = 1'b0;
        recv_val = 1'b1;
        recv_msg = 32'h11;
        tick();
        recv_msg = 32'h22;
        tick();
        chk("sq_pre_count", 64'(count), 64'd2);
        recv_msg = 32'h33;
        send_rdy = 1'b1;
        squash   = 1'b1;
        #1;
        chk("sq_send_val", 64'(send_val), 64'd0);
        chk("sq_recv_rdy", 64'(recv_rdy), 64'd0);
        tick();
        squash   = 1'b0;
        recv_val = 1'b0;
        #1;
        chk("sq_count", 64'(count), 64'd0);
        chk("sq_send_val_after", 64'(send_val), 64'd0);
        tick();
`endif

        // randomized traffic against a queue model
        q.delete();
        pushed = 0;
        sent   = 0;
        cyc    = 0;
        while (sent < 10000 && cyc < 60000) begin
            recv_val = (pushed < 10000) && ($urandom_range(0, 3) != 0);
            send_rdy = ($urandom_range(0, 3) != 0);
            recv_msg = $urandom;
            #1;
            esv = (q.size() > 0);
            err = (q.size() < 2);
            esm = esv ? q[0] : 32'd0;
            chk("rand",
                {29'd0, send_val, send_val ? send_msg : 32'd0,
                 recv_rdy, count},
                {29'd0, esv, esm, err, 2'(q.size())});
            do_send = esv && send_rdy;
            do_recv = recv_val && err;
            if (do_send) begin
                void'(q.pop_front());
                sent++;
            end
            if (do_recv) begin
                q.push_back(recv_msg);
                pushed++;
            end
            tick();
            cyc++;
        end
        chk("rand_all_sent", 64'(sent), 64'd10000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vc_skid_reg.md
VC_SKID_REG -- requirements
Module: vc_skid_reg

Interface
REQ-001: Parameter p_nbits SHALL default to 32 and set the message width in bits.
REQ-002: Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-003: Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-004: Port recv_val SHALL be an input, 1 bit wide, and SHALL signal an upstream message valid.
REQ-005: Port recv_rdy SHALL be an output, 1 bit wide, and SHALL signal that the block can accept a message.
REQ-006: Port recv_msg SHALL be an input, p_nbits wide, and SHALL carry the upstream message.
REQ-007: Port send_val SHALL be an output, 1 bit wide, and SHALL signal a downstream message valid.
REQ-008: Port send_rdy SHALL be an input, 1 bit wide, and SHALL signal that downstream can accept.
REQ-009: Port send_msg SHALL be an output, p_nbits wide, and SHALL carry the downstream message.
REQ-010: Port count SHALL be an output, 2 bits wide, and SHALL give occupancy (0, 1 or 2).
REQ-011: Port squash SHALL be an input, 1 bit wide, and SHALL flush all entries; it SHALL exist only when VC_SKID_REG_SQUASH_EN is defined.

Function
REQ-012: A transfer SHALL occur on a side only in a cycle where both val and rdy are 1 at the rising edge.
REQ-013: The block SHALL hold a main register and a skid register, tracked by state EMPTY, ONE or FULL (count 0, 1, 2).
REQ-014: send_val SHALL be 1 iff the state is not EMPTY, and send_msg SHALL always drive the main register.
REQ-015: recv_rdy SHALL be 1 iff the state is not FULL; it SHALL depend on registered state only, with no combinational path from send_rdy.
REQ-016: From EMPTY, a recv transfer SHALL load main and move to ONE; otherwise the state SHALL stay EMPTY.
REQ-017: From ONE, a recv and send transfer in the same cycle SHALL load main with recv_msg and stay in ONE.
REQ-018: From ONE, a recv transfer alone SHALL load skid and move to FULL.
REQ-019: From ONE, a send transfer alone SHALL move to EMPTY.
REQ-020: From ONE, with no transfer, the state SHALL stay ONE.
REQ-021: From FULL, a send transfer SHALL copy skid to main and move to ONE; otherwise the state SHALL hold, and no recv is possible.
REQ-022: Latency SHALL be one cycle from a recv transfer to send_val=1 with that message.
REQ-023: Sustained throughput SHALL be one message per cycle.
REQ-024: Messages SHALL leave in arrival order, with none lost or duplicated.
REQ-025: Registers not loaded in a cycle SHALL hold their value; the contents of an unoccupied register are don't-care.
REQ-026: An upstream that drops recv_val without a transfer SHALL cause no state change.
REQ-027: A downstream that stalls indefinitely SHALL leave the block FULL with both messages held.

Reset
REQ-028: While reset=1, the state SHALL be EMPTY, count 0, send_val 0 and recv_rdy 0, with main and skid cleared to 0, independent of clk.
REQ-029: recv_rdy SHALL be 1 in the first cycle after reset deasserts.
REQ-030: Reset asserted mid-operation SHALL discard all held messages immediately.

Configuration
REQ-031: With VC_SKID_REG_SQUASH_EN defined, squash=1 SHALL force send_val=0 and recv_rdy=0 that cycle and set the state to EMPTY at the next edge.
REQ-032: squash SHALL take priority over every transfer, so no transfer SHALL occur in a squash cycle.
REQ-033: Without VC_SKID_REG_SQUASH_EN, the squash port and all its logic SHALL be absent, with behaviour identical to squash held at 0.

Verification
REQ-034: Reset, then recv 0xA5 with send_rdy=1 -> send_val=1 and send_msg=0xA5 in the next cycle, count=1.
REQ-035: Streaming 0x1..0x8 with both rdy=1 every cycle -> outputs 0x1..0x8 on consecutive cycles, count stays 1, recv_rdy stays 1.
REQ-036: send_rdy=0, recv 0x11 then 0x22 -> count=2 and recv_rdy=0; send_rdy=1 -> 0x11 then 0x22, then count 0.
REQ-037: FULL state, reset pulsed between clock edges -> send_val=0, recv_rdy=0 and count=0 immediately; after release recv_rdy=1.
REQ-038: VC_SKID_REG_SQUASH_EN defined, FULL, squash=1 for one cycle -> send_val=0 that cycle, count=0 next cycle, with 0x11 and 0x22 never sent.
REQ-039: Random val/rdy toggling over 10000 messages -> output sequence matches input sequence exactly.
